key_search_controller: RTL and testbench



---
 rtl/key_search_controller.sv | 141 ++++++++++++++
 tb/tb_key_search_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_controller.sv
// Sequential key lookup: walks a synchronous-read table from address 0 and
// time-shares one external equality comparator, reporting the first match.
module key_search_controller #(
    parameter int unsigned N      = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N-1:0]      key,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] index,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_data,
    output logic [N-1:0]      cmp_a,
    output logic [N-1:0]      cmp_b,
    input  logic              cmp_eq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N-1:0]        key_q, key_d;
    logic                found_q, found_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    // Next-state and registered-output logic; abort overrides in READ/CMP.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        key_d      = key_q;
        found_d    = found_q;
        index_d    = index_q;
        mem_addr_d = mem_addr_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_rd_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d      = key;
                    addr_d     = '0;
                    found_d    = 1'b0;
                    index_d    = '0;
                    state_d    = S_READ;
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                    found_d = 1'b0;
                end else begin
                    state_d = S_CMP;
                    busy_d  = 1'b1;
                end
            end
            S_CMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    found_d = 1'b0;
                end else if (cmp_eq) begin
                    found_d = 1'b1;
                    index_d = addr_q;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    found_d = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d     = addr_q + ADDR_W'(1);
                    state_d    = S_READ;
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            key_q      <= '0;
            found_q    <= 1'b0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            key_q      <= key_d;
            found_q    <= found_d;
            index_q    <= index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign index    = index_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign cmp_a    = key_q;
    assign cmp_b    = mem_data;

endmodule

// File: tb/tb_key_search_controller.sv
// Directed scoreboard bench for key_search_controller: three instances
// (DEPTH 16, 1, 5) with behavioural memories and comparators.
module tb_key_search_controller;

    localparam int unsigned N  = 32;
    localparam int unsigned AW = 4;

    typedef struct {
        bit             found;
        logic [AW-1:0]  idx;
        int             done_edge;
        int             nr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         abort;
    logic [N-1:0] key;
    logic         start_a, start_b, start_c;

    logic          busy_a, done_a, found_a, mem_rd_a, cmp_eq_a;
    logic [AW-1:0] index_a, mem_addr_a;
    logic [N-1:0]  cmp_a_a, cmp_b_a, mem_data_a;
    logic          busy_b, done_b, found_b, mem_rd_b, cmp_eq_b;
    logic [AW-1:0] index_b, mem_addr_b;
    logic [N-1:0]  cmp_a_b, cmp_b_b, mem_data_b;
    logic          busy_c, done_c, found_c, mem_rd_c, cmp_eq_c;
    logic [AW-1:0] index_c, mem_addr_c;
    logic [N-1:0]  cmp_a_c, cmp_b_c, mem_data_c;

    logic [N-1:0] mem_a [16];
    logic [N-1:0] mem_b [16];
    logic [N-1:0] mem_c [16];

    int vectors = 0;
    int miscompares = 0;
    exp_t sb_q[$];

    key_search_controller #(.N(N), .DEPTH(16), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .key(key),
        .busy(busy_a), .done(done_a), .found(found_a), .index(index_a),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .cmp_a(cmp_a_a), .cmp_b(cmp_b_a), .cmp_eq(cmp_eq_a)
    );
    key_search_controller #(.N(N), .DEPTH(1), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .key(key),
        .busy(busy_b), .done(done_b), .found(found_b), .index(index_b),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .cmp_a(cmp_a_b), .cmp_b(cmp_b_b), .cmp_eq(cmp_eq_b)
    );
    key_search_controller #(.N(N), .DEPTH(5), .ADDR_W(AW)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort), .key(key),
        .busy(busy_c), .done(done_c), .found(found_c), .index(index_c),
        .mem_rd(mem_rd_c), .mem_addr(mem_addr_c), .mem_data(mem_data_c),
        .cmp_a(cmp_a_c), .cmp_b(cmp_b_c), .cmp_eq(cmp_eq_c)
    );

    // Synchronous-read tables and shared equality comparators.
    always @(posedge clk) begin
        if (mem_rd_a) mem_data_a <= mem_a[mem_addr_a];
        if (mem_rd_b) mem_data_b <= mem_b[mem_addr_b];
        if (mem_rd_c) mem_data_c <= mem_c[mem_addr_c];
    end
    assign cmp_eq_a = (cmp_a_a == cmp_b_a);
    assign cmp_eq_b = (cmp_a_b == cmp_b_b);
    assign cmp_eq_c = (cmp_a_c == cmp_b_c);

    int            sel;
    logic          m_busy, m_done, m_found, m_mem_rd;
    logic [AW-1:0] m_index, m_mem_addr;
    logic [N-1:0]  m_cmp_a;

    always_comb begin
        case (sel)
            1: begin
                m_busy = busy_b; m_done = done_b; m_found = found_b; m_mem_rd = mem_rd_b;
                m_index = index_b; m_mem_addr = mem_addr_b; m_cmp_a = cmp_a_b;
            end
            2: begin
                m_busy = busy_c; m_done = done_c; m_found = found_c; m_mem_rd = mem_rd_c;
                m_index = index_c; m_mem_addr = mem_addr_c; m_cmp_a = cmp_a_c;
            end
            default: begin
                m_busy = busy_a; m_done = done_a; m_found = found_a; m_mem_rd = mem_rd_a;
                m_index = index_a; m_mem_addr = mem_addr_a; m_cmp_a = cmp_a_a;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       start_b = v;
            2:       start_c = v;
            default: start_a = v;
        endcase
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",     32'(m_busy),     32'd0);
        chk("rst_done",     32'(m_done),     32'd0);
        chk("rst_found",    32'(m_found),    32'd0);
        chk("rst_index",    32'(m_index),    32'd0);
        chk("rst_mem_rd",   32'(m_mem_rd),   32'd0);
        chk("rst_mem_addr", 32'(m_mem_addr), 32'd0);
        chk("rst_cmp_a",    m_cmp_a,         32'd0);
    endtask

    // mode 0: plain, 1: abort at CMP of entry 3, 2: start+key change in READ, 3: reset mid-READ
    task automatic run(input int s, input logic [N-1:0] k, input int mode,
                       input bit ef, input logic [AW-1:0] ei, input int ee, input int enr);
        exp_t ex;
        int   e;
        int   nreads;
        bit   got;
        sb_q.push_back('{found: ef, idx: ei, done_edge: ee, nr: enr});
        @(negedge clk);
        chk("done_one_cycle", 32'(m_done), 32'd0);
        sel = s;
        key = k;
        set_start(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(s, 1'b0);
        e = 0; nreads = 0; got = 1'b0;
        chk("start_clears_found", 32'(m_found), 32'd0);
        chk("start_clears_index", 32'(m_index), 32'd0);
        chk("cmp_a_latched",      m_cmp_a,      k);
        for (int c = 0; c < 80; c++) begin
            if (mode == 1 && e == 8) begin
                abort = 1'b0;
                chk("abort_busy",  32'(m_busy),  32'd0);
                chk("abort_done",  32'(m_done),  32'd0);
                chk("abort_found", 32'(m_found), 32'd0);
                break;
            end
            if (mode == 3 && e == 2) begin
                rst = 1'b1;
                #1;
                check_reset_outputs();
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (m_mem_rd) begin
                chk("rd_addr", 32'(m_mem_addr), 32'(nreads));
                chk("rd_edge", 32'(e), 32'(2 * nreads));
                nreads++;
            end
            if (m_done) begin
                got = 1'b1;
                break;
            end
            chk("busy_running", 32'(m_busy), 32'd1);
            if (mode == 1 && e == 7) abort = 1'b1;
            if (mode == 2 && e == 2) begin
                set_start(s, 1'b1);
                key = 32'd6;
            end
            if (mode == 2 && e == 3) begin
                set_start(s, 1'b0);
                chk("cmp_a_holds_key", m_cmp_a, k);
            end
            @(negedge clk);
            e++;
        end
        ex = sb_q.pop_front();
        if (mode == 0 || mode == 2) begin
            chk("done_seen",  32'(got),     32'd1);
            chk("done_edge",  32'(e),       32'(ex.done_edge));
            chk("found",      32'(m_found), 32'(ex.found));
            if (ex.found) chk("index", 32'(m_index), 32'(ex.idx));
            chk("read_count", 32'(nreads),  32'(ex.nr));
            chk("busy_in_done", 32'(m_busy), 32'd0);
        end else begin
            for (int c = 0; c < 3; c++) begin
                chk("no_done_after_cancel", 32'(m_done), 32'd0);
                chk("idle_after_cancel",    32'(m_busy), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; key = '0; sel = 0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'(i * 3);
            mem_b[i] = 32'h5555_0000 + 32'(i);
            mem_c[i] = 32'd100 + 32'(i);
        end
        mem_b[0] = 32'h1234;

        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        run(0, 32'd15,         0, 1'b1, 4'd5, 12, 6);
        run(0, 32'd15,         0, 1'b1, 4'd5, 12, 6);
        run(0, 32'hDEADBEEF,   0, 1'b0, 4'd0, 32, 16);
        run(0, 32'd15,         2, 1'b1, 4'd5, 12, 6);
        run(0, 32'd15,         1, 1'b0, 4'd0, 0,  0);
        mem_a[2] = 32'hA5;
        mem_a[9] = 32'hA5;
        run(0, 32'hA5,         0, 1'b1, 4'd2, 6,  3);
        run(1, 32'h1234,       0, 1'b1, 4'd0, 2,  1);
        run(2, 32'd7,          0, 1'b0, 4'd0, 10, 5);
        run(0, 32'hDEADBEEF,   3, 1'b0, 4'd0, 0,  0);
        run(0, 32'd15,         0, 1'b1, 4'd5, 12, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
